// File: rtl/bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural order.
// Two ping-pong banks: one is filled while the other is drained in bit-reversed address order.
module bitrev_reorder #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_ip,
    input  logic [W-1:0] ip_re,
    input  logic [W-1:0] ip_im,
    output logic [W-1:0] op_re,
    output logic [W-1:0] op_im,
    output logic         op_valid,
    output logic         start_op
);

    localparam int DEPTH = 2 ** N;
    localparam logic [N-1:0] LAST = '1;

    typedef enum logic { W_IDLE, W_FILL } wstate_t;
    typedef enum logic { R_IDLE, R_DRAIN } rstate_t;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic [N-1:0] wr_idx, wr_idx_next, wr_addr;
    logic [N-1:0] rd_idx, rd_idx_next;
    logic         wr_bank;
    logic         wr_en;
    logic         frame_done;
    logic         drain;

    logic [W-1:0] mem_re [2][DEPTH];
    logic [W-1:0] mem_im [2][DEPTH];

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            bitrev[i] = v[N-1-i];
        end
    endfunction

    // Write side: start_ip always restarts at index 0 of the current write bank.
    always_comb begin
        w_next      = w_state;
        wr_idx_next = wr_idx;
        wr_addr     = wr_idx;
        wr_en       = 1'b0;
        frame_done  = 1'b0;
        if (start_ip) begin
            wr_en       = 1'b1;
            wr_addr     = '0;
            wr_idx_next = N'(1);
            w_next      = W_FILL;
        end else if (w_state == W_FILL) begin
            wr_en = 1'b1;
            if (wr_idx == LAST) begin
                frame_done  = 1'b1;
                wr_idx_next = '0;
                w_next      = W_IDLE;
            end else begin
                wr_idx_next = wr_idx + 1'b1;
            end
        end
    end

    // A completed frame restarts the drain even on the edge that emits the previous frame's last sample.
    always_comb begin
        r_next      = r_state;
        rd_idx_next = rd_idx;
        drain       = 1'b0;
        if (r_state == R_DRAIN) begin
            drain       = 1'b1;
            rd_idx_next = rd_idx + 1'b1;
            if (rd_idx == LAST) begin
                r_next = R_IDLE;
            end
        end
        if (frame_done) begin
            r_next      = R_DRAIN;
            rd_idx_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_bank <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            wr_idx  <= wr_idx_next;
            rd_idx  <= rd_idx_next;
            if (frame_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_re[wr_bank][wr_addr] <= ip_re;
            mem_im[wr_bank][wr_addr] <= ip_im;
        end
    end

    // The read bank is always the one not being written.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_re    <= '0;
            op_im    <= '0;
            op_valid <= 1'b0;
            start_op <= 1'b0;
        end else begin
            op_valid <= drain;
            start_op <= drain && (rd_idx == '0);
            if (drain) begin
                op_re <= mem_re[~wr_bank][bitrev(rd_idx)];
                op_im <= mem_im[~wr_bank][bitrev(rd_idx)];
            end
        end
    end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed table-driven bench for bitrev_reorder with N=3, W=32.
module tb_bitrev_reorder;

    logic        clk;
    logic        reset;
    logic        start_ip;
    logic [31:0] ip_re;
    logic [31:0] ip_im;
    logic [31:0] op_re;
    logic [31:0] op_im;
    logic        op_valid;
    logic        start_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          scen;
        logic        rst;
        logic        st;
        logic [31:0] re;
        logic [31:0] im;
        logic        ev;
        logic        es;
        logic        cd;
        logic [31:0] ere;
        logic [31:0] eim;
    } vec_t;

    vec_t tbl[$];
    int   ord[8];

    bitrev_reorder #(.N(3), .W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_ip (start_ip),
        .ip_re    (ip_re),
        .ip_im    (ip_im),
        .op_re    (op_re),
        .op_im    (op_im),
        .op_valid (op_valid),
        .start_op (start_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] neg(input int v);
        return 32'(-v);
    endfunction

    task automatic add_vec(input int scen, input logic rst, input logic st, input int re,
                           input logic ev, input logic es, input logic cd, input int ere);
        vec_t v;
        v.scen = scen;
        v.rst  = rst;
        v.st   = st;
        v.re   = 32'(re);
        v.im   = neg(re);
        v.ev   = ev;
        v.es   = es;
        v.cd   = cd;
        v.ere  = 32'(ere);
        v.eim  = neg(ere);
        tbl.push_back(v);
    endtask

    // Inputs are set, then the edge is taken and outputs settle for 1 time unit.
    task automatic apply_stimulus(input logic rst, input logic st, input logic [31:0] re,
                                  input logic [31:0] im);
        reset    = rst;
        start_ip = st;
        ip_re    = re;
        ip_im    = im;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic ev, input logic es,
                                input logic cd, input logic [31:0] ere, input logic [31:0] eim);
        checks++;
        if (op_valid !== ev || start_op !== es || (cd && (op_re !== ere || op_im !== eim))) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b start=%b re=%0d im=%0d, want valid=%b start=%b re=%0d im=%0d (data %s)",
                     name, op_valid, start_op, $signed(op_re), $signed(op_im),
                     ev, es, $signed(ere), $signed(eim), cd ? "checked" : "ignored");
        end
    endtask

    initial begin
        string nm;
        reset    = 1'b1;
        start_ip = 1'b0;
        ip_re    = '0;
        ip_im    = '0;
        ord      = '{1, 5, 3, 7, 2, 6, 4, 8};

        // Scenario 0: reset state
        add_vec(0, 1, 0, 0, 0, 0, 1, 0);
        add_vec(0, 1, 0, 0, 0, 0, 1, 0);

        // Scenario 1: single frame, then idle with held data
        for (int k = 0; k < 8; k++) add_vec(1, 0, k == 0, k + 1, 0, 0, 1, 0);
        for (int j = 0; j < 8; j++) add_vec(1, 0, 0, 0, 1, j == 0, 1, ord[j]);
        for (int i = 0; i < 3; i++) add_vec(1, 0, 0, 0, 0, 0, 1, 8);

        // Scenario 2: two back-to-back frames stream without a gap
        for (int k = 0; k < 8; k++) add_vec(2, 0, k == 0, k + 1, 0, 0, 1, 8);
        for (int k = 0; k < 8; k++) add_vec(2, 0, k == 0, k + 11, 1, k == 0, 1, ord[k]);
        for (int j = 0; j < 8; j++) add_vec(2, 0, 0, 0, 1, j == 0, 1, ord[j] + 10);
        for (int i = 0; i < 2; i++) add_vec(2, 0, 0, 0, 0, 0, 1, 18);

        // Scenario 3: partial frame aborted by a fresh start_ip
        for (int k = 0; k < 4; k++) add_vec(3, 0, k == 0, 100 + k, 0, 0, 1, 18);
        for (int k = 0; k < 8; k++) add_vec(3, 0, k == 0, k + 21, 0, 0, 1, 18);
        for (int j = 0; j < 8; j++) add_vec(3, 0, 0, 0, 1, j == 0, 1, ord[j] + 20);
        for (int i = 0; i < 6; i++) add_vec(3, 0, 0, 0, 0, 0, 1, 28);

        // Scenario 4: reset at drain output 3, stray samples, then recovery
        for (int k = 0; k < 8; k++) add_vec(4, 0, k == 0, k + 31, 0, 0, 1, 28);
        for (int j = 0; j < 3; j++) add_vec(4, 0, 0, 0, 1, j == 0, 1, ord[j] + 30);
        add_vec(4, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) add_vec(4, 0, 0, 60 + i, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) add_vec(4, 0, k == 0, k + 41, 0, 0, 1, 0);
        for (int j = 0; j < 8; j++) add_vec(4, 0, 0, 0, 1, j == 0, 1, ord[j] + 40);
        add_vec(4, 0, 0, 0, 0, 0, 1, 48);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i].rst, tbl[i].st, tbl[i].re, tbl[i].im);
            nm = $sformatf("scen%0d_vec%0d", tbl[i].scen, i);
            check_output(nm, tbl[i].ev, tbl[i].es, tbl[i].cd, tbl[i].ere, tbl[i].eim);
        end

        // Reset and start_ip together: the sample must not start a frame
        apply_stimulus(1'b1, 1'b1, 32'd77, neg(77));
        check_output("rst_with_start", 1'b0, 1'b0, 1'b1, '0, '0);
        for (int k = 1; k < 8; k++) begin
            apply_stimulus(1'b0, 1'b0, 32'(90 + k), neg(90 + k));
            check_output("rst_start_ignored", 1'b0, 1'b0, 1'b1, '0, '0);
        end
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b0, '0, '0);
            check_output("rst_start_quiet", 1'b0, 1'b0, 1'b1, '0, '0);
        end

        // A normal frame afterwards still reorders correctly
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b0, k == 0, 32'(k + 51), neg(k + 51));
            check_output("final_fill", 1'b0, 1'b0, 1'b1, '0, '0);
        end
        for (int j = 0; j < 8; j++) begin
            apply_stimulus(1'b0, 1'b0, '0, '0);
            check_output("final_drain", 1'b1, j == 0, 1'b1, 32'(ord[j] + 50), neg(ord[j] + 50));
        end
        apply_stimulus(1'b0, 1'b0, '0, '0);
        check_output("final_idle", 1'b0, 1'b0, 1'b1, 32'd58, neg(58));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitrev_reorder.md
BITREV_REORDER -- requirements
Module: bitrev_reorder

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning log2 of the FFT size (frame = 2^N samples).
REQ-002 The block SHALL have parameter W, default 32, meaning the width of one real or imaginary part, matching the fixed-point fpt word.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-005 The block SHALL have port start_ip, input, 1 bit, meaning a one-cycle pulse marking sample 0 of a frame from the last butterfly stage.
REQ-006 The block SHALL have port ip_re, input, W bits, meaning the real part of the input sample.
REQ-007 The block SHALL have port ip_im, input, W bits, meaning the imaginary part of the input sample.
REQ-008 The block SHALL have port op_re, output, W bits, meaning the real part of the registered output sample.
REQ-009 The block SHALL have port op_im, output, W bits, meaning the imaginary part of the registered output sample.
REQ-010 The block SHALL have port op_valid, output, 1 bit, meaning op_re and op_im hold a valid sample.
REQ-011 The block SHALL have port start_op, output, 1 bit, meaning a one-cycle pulse coincident with output sample 0 of a frame.

Function
REQ-012 The block SHALL convert bit-reversed-order SDF output into natural order: output j of a frame = input sample bitrev_N(j).
REQ-013 The block SHALL hold two banks of 2^N complex words (ping-pong): one bank is written while the other is drained.
REQ-014 Write FSM states SHALL be W_IDLE and W_FILL; start_ip in any state writes the current sample to index 0 of the write bank and moves the FSM to W_FILL with next index 1.
REQ-015 In W_FILL without start_ip, the block SHALL write the sample at index k and then increment k; when k = 2^N-1 is written, the frame is complete and the FSM moves to W_IDLE.
REQ-016 In W_IDLE, samples without start_ip SHALL be ignored.
REQ-017 start_ip arriving in W_FILL before frame completion SHALL abort the partial frame and restart at index 0 in the same bank; no output is produced for the aborted frame.
REQ-018 On frame completion, the write bank and read bank SHALL swap, and the read FSM SHALL go from R_IDLE or R_DRAIN to R_DRAIN with read index 0 at that same edge.
REQ-019 In R_DRAIN, each edge SHALL register bank[bitrev(j)] into op_re/op_im, assert op_valid, and increment j.
REQ-020 After j = 2^N-1 is output, the read FSM SHALL return to R_IDLE and op_valid SHALL fall on the following edge.
REQ-021 Latency: if sample 0 is captured at edge e0, output j SHALL appear after edge e0+2^N+j, with start_op high only in the cycle after edge e0+2^N.
REQ-022 Back-to-back frames, with start_ip at e0+2^N, SHALL stream continuously with op_valid held high and no gap or duplicate sample.
REQ-023 Frame spacing is always at least 2^N cycles, so a drain never overlaps a bank swap; no additional arbitration is required.
REQ-024 Data SHALL pass through bit-exact, with no arithmetic, rounding or sign change.
REQ-025 When op_valid is low, op_re and op_im SHALL hold their last value.

Reset
REQ-026 When reset is high at an edge, the FSMs SHALL go to W_IDLE/R_IDLE, indices and bank select SHALL clear to 0, and op_re, op_im, op_valid and start_op SHALL be 0.
REQ-027 Reset SHALL take precedence over a simultaneous start_ip.
REQ-028 Reset mid-frame or mid-drain SHALL discard all buffered data, and no output SHALL appear until a new full frame is received.
REQ-029 Buffer RAM contents need not be cleared by reset.

Verification (N=3)
REQ-030 Bench SHALL drive one frame with ip_re = k+1 and ip_im = -(k+1) for k = 0..7 -> op_re sequence 1,5,3,7,2,6,4,8 with matching negated op_im, start_op on the first output, and op_valid high for exactly 8 cycles.
REQ-031 Bench SHALL drive two back-to-back frames (second frame values +10) -> 16 contiguous valid outputs: 1,5,3,7,2,6,4,8,11,15,13,17,12,16,14,18, with exactly two start_op pulses 8 cycles apart.
REQ-032 Bench SHALL drive start_ip, 4 samples, then start_ip again with a full frame -> only the second frame is output, 8 outputs, and no output is derived from the aborted samples.
REQ-033 Bench SHALL assert reset at drain output 3 -> outputs go to 0 on the next edge and no further valid outputs occur until a new complete frame arrives.
REQ-034 Bench SHALL drive samples without start_ip after reset -> op_valid and start_op stay 0.
REQ-035 Bench SHALL drive start_ip and reset in the same cycle -> reset wins, and the sample is not written.
